// File: rtl/pulse_meter.sv
// Measures period and high time of an asynchronous pulse train in sysclk cycles,
// averaged over 2^AVG_LOG2 periods, with a one-cycle result strobe and loss-of-signal flag.
module pulse_meter #(
  parameter int CNT_W    = 32,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 50000000
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             Pulse_In,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] High_Time,
  output logic             Valid,
  output logic             No_Signal
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  // n needs at least one bit even when no averaging is configured
  localparam int N_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [N_W-1:0]   N_LAST    = N_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] per_cnt_q, hi_cnt_q;
  logic [ACC_W-1:0] acc_per_q, acc_hi_q;
  logic [N_W-1:0]   n_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             valid_q, no_signal_q;

  logic             rise;
  logic [ACC_W-1:0] sum_per_d, sum_hi_d;
  logic [CNT_W-1:0] period_d, high_time_d;

  assign rise        = s2_q & ~s3_q;
  assign sum_per_d   = acc_per_q + ACC_W'(per_cnt_q);
  assign sum_hi_d    = acc_hi_q + ACC_W'(hi_cnt_q);
  assign period_d    = CNT_W'(sum_per_d >> AVG_LOG2);
  assign high_time_d = CNT_W'(sum_hi_d >> AVG_LOG2);

  // Two-flop synchronizer plus delay flop for edge detection
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Pulse_In;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Measurement FSM with counters, accumulators and registered outputs
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      acc_per_q   <= '0;
      acc_hi_q    <= '0;
      n_q         <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          acc_per_q <= '0;
          acc_hi_q  <= '0;
          n_q       <= '0;
          if (rise) begin
            per_cnt_q <= CNT_ONE;
            hi_cnt_q  <= CNT_ONE;
            state_q   <= MEASURE;
          end else begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            state_q   <= IDLE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise closes a period and opens the next one
            if (n_q < N_LAST) begin
              acc_per_q <= sum_per_d;
              acc_hi_q  <= sum_hi_d;
              n_q       <= n_q + N_W'(1);
            end else begin
              period_q    <= period_d;
              high_time_q <= high_time_d;
              valid_q     <= 1'b1;
              no_signal_q <= 1'b0;
              acc_per_q   <= '0;
              acc_hi_q    <= '0;
              n_q         <= '0;
            end
            per_cnt_q <= CNT_ONE;
            hi_cnt_q  <= CNT_ONE;
            state_q   <= MEASURE;
          end else if (per_cnt_q >= TIMEOUT_C) begin
            period_q    <= '0;
            high_time_q <= '0;
            no_signal_q <= 1'b1;
            acc_per_q   <= '0;
            acc_hi_q    <= '0;
            n_q         <= '0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            state_q     <= IDLE;
          end else begin
            per_cnt_q <= per_cnt_q + CNT_ONE;
            hi_cnt_q  <= hi_cnt_q + CNT_W'(s2_q);
            state_q   <= MEASURE;
          end
        end
        default: begin
          state_q   <= IDLE;
          per_cnt_q <= '0;
          hi_cnt_q  <= '0;
          acc_per_q <= '0;
          acc_hi_q  <= '0;
          n_q       <= '0;
        end
      endcase
    end
  end

  assign Period    = period_q;
  assign High_Time = high_time_q;
  assign Valid     = valid_q;
  assign No_Signal = no_signal_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: table of 4-period averaging vectors plus
// hand sequences for reset, steady stream, timeout/restart and no-averaging.
module tb_pulse_meter;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        pulse_a = 1'b0;
  logic        pulse_b = 1'b0;
  logic [31:0] period_a, high_a, period_b, high_b;
  logic        valid_a, nosig_a, valid_b, nosig_b;

  pulse_meter #(.CNT_W(32), .AVG_LOG2(2), .TIMEOUT(100)) dut_a (
    .sysclk(sysclk), .reset(reset), .Pulse_In(pulse_a),
    .Period(period_a), .High_Time(high_a), .Valid(valid_a), .No_Signal(nosig_a)
  );

  pulse_meter #(.CNT_W(32), .AVG_LOG2(0), .TIMEOUT(100)) dut_b (
    .sysclk(sysclk), .reset(reset), .Pulse_In(pulse_b),
    .Period(period_b), .High_Time(high_b), .Valid(valid_b), .No_Signal(nosig_b)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for dut_a result strobes and No_Signal rising edges
  int va_per[$];
  int va_hi[$];
  int va_cyc[$];
  int va_ns[$];
  int consec_a = 0;
  int ns_rise_cyc = -1;
  initial begin
    automatic logic prev_v  = 1'b0;
    automatic logic prev_ns = 1'b1;
    forever begin
      @(negedge sysclk);
      if (valid_a) begin
        va_per.push_back(int'(period_a));
        va_hi.push_back(int'(high_a));
        va_cyc.push_back(cyc);
        va_ns.push_back(int'(nosig_a));
        if (prev_v) consec_a++;
      end
      prev_v = valid_a;
      if (nosig_a && !prev_ns) ns_rise_cyc = cyc;
      prev_ns = nosig_a;
    end
  end

  int vb_count = 0;
  int vb_bad   = 0;
  initial begin
    forever begin
      @(negedge sysclk);
      if (valid_b) begin
        vb_count++;
        if (period_b != 32'd2 || high_b != 32'd1) vb_bad++;
      end
    end
  end

  int last_rise_cyc = 0;

  task automatic pulse_a_gen(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge sysclk);
      pulse_a = (i < h);
      if (i == 0) last_rise_cyc = cyc;
    end
  endtask

  task automatic clear_a();
    va_per.delete();
    va_hi.delete();
    va_cyc.delete();
    va_ns.delete();
  endtask

  typedef struct {
    int p0, p1, p2, p3;
    int h0, h1, h2, h3;
    int ep, eh;
  } vec_t;

  vec_t tab[6];

  initial begin
    int pp[4];
    int hh[4];
    int c5;

    tab[0] = '{10, 10, 10, 10, 3, 3, 3, 3, 10, 3};
    tab[1] = '{9, 11, 9, 11, 4, 4, 4, 4, 10, 4};
    tab[2] = '{9, 9, 9, 10, 4, 4, 4, 4, 9, 4};
    tab[3] = '{2, 2, 2, 2, 1, 1, 1, 1, 2, 1};
    tab[4] = '{7, 7, 8, 8, 6, 6, 7, 7, 7, 6};
    tab[5] = '{5, 6, 7, 9, 1, 2, 3, 4, 6, 2};

    // Reset held while both inputs toggle
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      pulse_a = ~pulse_a;
      pulse_b = ~pulse_b;
      check("rst_period", period_a, 0);
      check("rst_high", high_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_nosig", nosig_a, 1);
    end
    check("rst_b_valids", vb_count, 0);
    @(negedge sysclk);
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);

    // Steady 10/3 stream: 13 rises give three results, 40 cycles apart
    clear_a();
    for (int k = 0; k < 13; k++) begin
      pulse_a_gen(10, 3);
      if (k == 4) c5 = last_rise_cyc;
    end
    check("steady_count", va_per.size(), 3);
    if (va_per.size() == 3) begin
      check("steady_latency", va_cyc[0], c5 + 3);
      check("steady_gap1", va_cyc[1] - va_cyc[0], 40);
      check("steady_gap2", va_cyc[2] - va_cyc[1], 40);
      for (int j = 0; j < 3; j++) begin
        check("steady_period", va_per[j], 10);
        check("steady_high", va_hi[j], 3);
        check("steady_nosig", va_ns[j], 0);
      end
    end
    check("hold_period", period_a, 10);
    check("hold_high", high_a, 3);

    // Input stops low: loss of signal 100 cycles after per_cnt=1 of last rise
    c5 = last_rise_cyc;
    ns_rise_cyc = -1;
    repeat (120) @(negedge sysclk);
    check("timeout_cycle", ns_rise_cyc, c5 + 103);
    check("timeout_period", period_a, 0);
    check("timeout_high", high_a, 0);
    check("timeout_nosig", nosig_a, 1);

    // Restart needs 1 + 4 rises before the next result
    clear_a();
    for (int k = 0; k < 4; k++) pulse_a_gen(10, 3);
    check("restart_early", va_per.size(), 0);
    pulse_a_gen(5, 3);
    check("restart_count", va_per.size(), 1);
    if (va_per.size() == 1) begin
      check("restart_period", va_per[0], 10);
      check("restart_latency", va_cyc[0], last_rise_cyc + 3);
    end
    repeat (120) @(negedge sysclk);

    // Table of four-period averaging vectors, each started from IDLE
    for (int v = 0; v < 6; v++) begin
      pp[0] = tab[v].p0; pp[1] = tab[v].p1; pp[2] = tab[v].p2; pp[3] = tab[v].p3;
      hh[0] = tab[v].h0; hh[1] = tab[v].h1; hh[2] = tab[v].h2; hh[3] = tab[v].h3;
      clear_a();
      for (int k = 0; k < 4; k++) pulse_a_gen(pp[k], hh[k]);
      pulse_a_gen(2, 1);
      c5 = last_rise_cyc;
      repeat (120) @(negedge sysclk);
      check("vec_count", va_per.size(), 1);
      if (va_per.size() == 1) begin
        check("vec_period", va_per[0], tab[v].ep);
        check("vec_high", va_hi[0], tab[v].eh);
        check("vec_latency", va_cyc[0], c5 + 3);
      end
      check("vec_nosig_end", nosig_a, 1);
      check("vec_period_end", period_a, 0);
    end

    // Asynchronous reset between clock edges clears outputs immediately
    clear_a();
    for (int k = 0; k < 6; k++) pulse_a_gen(10, 3);
    check("pre_rst_period", period_a, 10);
    @(posedge sysclk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_period", period_a, 0);
    check("arst_high", high_a, 0);
    check("arst_valid", valid_a, 0);
    check("arst_nosig", nosig_a, 1);
    @(negedge sysclk);
    pulse_a = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);
    clear_a();
    for (int k = 0; k < 4; k++) pulse_a_gen(10, 3);
    check("arst_early", va_per.size(), 0);
    pulse_a_gen(5, 3);
    check("arst_count", va_per.size(), 1);
    if (va_per.size() == 1) begin
      check("arst_res_period", va_per[0], 10);
      check("arst_res_high", va_hi[0], 3);
    end
    check("consecutive_valid", consec_a, 0);

    // No averaging, input toggling every cycle: period 2, high 1
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      pulse_b = ~pulse_b;
    end
    vb_count = 0;
    vb_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      pulse_b = ~pulse_b;
    end
    check("b_valid_count", vb_count, 10);
    check("b_bad_values", vb_bad, 0);
    check("b_nosig", nosig_b, 0);
    check("b_period", period_b, 2);
    check("b_high", high_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
